// File: rtl/uart_receiver.sv
// 8N1 UART receive stage, 16x oversampled, writing good bytes into the receive FIFO.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over counter 6/7/8 with the decision moved to counter 8.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_rf,
  input  logic       rst_rf,
  input  logic       receiver_rx,
  input  logic       rf_full,
  output logic       rf_wr,
  output logic [7:0] rf_din,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] CNT_DEC  = 4'(OVERSAMPLE / 2);
`else
  localparam logic [3:0] CNT_DEC  = 4'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        rx_p0, rx_s;
  logic [3:0]  counter;
  logic [2:0]  bit_counter;
  logic [7:0]  shreg;
  logic        dec, bit_val;
  logic        wr_set, ferr_set, ovr_set;

  // Stage p0 -> rx_s: two-flop synchronizer, idles high
  always_ff @(posedge clk_rf or posedge rst_rf) begin
    if (rst_rf) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= receiver_rx;
      rx_s  <= rx_p0;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic v6, v7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk_rf or posedge rst_rf) begin
    if (rst_rf) begin
      v6 <= 1'b1;
      v7 <= 1'b1;
    end else begin
      if (counter == 4'd6) v6 <= rx_s;
      if (counter == 4'd7) v7 <= rx_s;
    end
  end

  assign bit_val = maj3(v6, v7, rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign dec  = (counter == CNT_DEC);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk_rf or posedge rst_rf) begin
    if (rst_rf) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_set    = 1'b0;
    ferr_set  = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: begin
        if (dec && bit_val)             state_nxt = S_IDLE;
        else if (counter == CNT_LAST)   state_nxt = S_DATA;
      end
      S_DATA:  if (counter == CNT_LAST && bit_counter == 3'd7) state_nxt = S_STOP;
      S_STOP: begin
        if (dec) begin
          if (bit_val) begin
            state_nxt = S_IDLE;
            if (rf_full) ovr_set = 1'b1;
            else         wr_set  = 1'b1;
          end else begin
            state_nxt = S_BRK;
            ferr_set  = 1'b1;
          end
        end
      end
      S_BRK:   if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter is held at 0 in IDLE and on the way back to it, so START always opens at 0
  always_ff @(posedge clk_rf or posedge rst_rf) begin
    if (rst_rf) begin
      counter     <= '0;
      bit_counter <= '0;
      shreg       <= '0;
      rf_din      <= '0;
      rf_wr       <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      counter <= (state == S_IDLE || state_nxt == S_IDLE) ? 4'd0 : counter + 4'd1;
      if (state == S_START)
        bit_counter <= '0;
      else if (state == S_DATA && counter == CNT_LAST)
        bit_counter <= bit_counter + 3'd1;
      if (state == S_DATA && dec)
        shreg <= {bit_val, shreg[7:1]};
      rf_wr     <= wr_set;
      frame_err <= ferr_set;
      overrun   <= ovr_set;
      if (wr_set) rf_din <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver against a frame-level expectation model.
module tb_uart_receiver;

  logic       clk_rf = 1'b0;
  logic       rst_rf = 1'b1;
  logic       receiver_rx = 1'b1;
  logic       rf_full = 1'b0;
  logic       rf_wr, frame_err, overrun, busy;
  logic [7:0] rf_din;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT  = 156;
  localparam int GOFF = 8;
`else
  localparam int LAT  = 155;
  localparam int GOFF = 3;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  // observed events, written only by the monitor
  logic [7:0]  got_d [0:63];
  int unsigned got_c [0:63];
  int n_wr = 0, n_ferr = 0, n_ovr = 0, n_overlap = 0, n_wide = 0;
  logic wr_q = 1'b0;

  // expected events, written only by the stimulus process
  logic [7:0]  exp_d [0:63];
  int unsigned exp_c [0:63];
  int n_exp = 0, rd_idx = 0, exp_ferr = 0, exp_ovr = 0;

  uart_receiver #(.OVERSAMPLE(16)) dut (
    .clk_rf(clk_rf), .rst_rf(rst_rf), .receiver_rx(receiver_rx), .rf_full(rf_full),
    .rf_wr(rf_wr), .rf_din(rf_din), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk_rf = ~clk_rf;
  always @(posedge clk_rf) cyc <= cyc + 1;

  always @(negedge clk_rf) begin
    wr_q <= rf_wr;
    if (rf_wr && wr_q) n_wide <= n_wide + 1;
    if ((32'(rf_wr) + 32'(frame_err) + 32'(overrun)) > 1) n_overlap <= n_overlap + 1;
    if (rf_wr) begin
      if (n_wr < 64) begin
        got_d[n_wr] <= rf_din;
        got_c[n_wr] <= cyc;
      end
      n_wr <= n_wr + 1;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun)   n_ovr  <= n_ovr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    receiver_rx = 1'b1;
    repeat (n) @(negedge clk_rf);
  endtask

  // Drives one 160-sample 8N1 frame; sample gidx is inverted. Stops early at abort_idx.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gidx, input int abort_idx);
    logic [9:0]  fb;
    int unsigned st;
    fb = {stop, d, 1'b0};
    st = 0;
    for (int s = 0; s < 160; s++) begin
      if (s == abort_idx) return;
      @(negedge clk_rf);
      if (s == 0) st = cyc;
      receiver_rx = fb[s / 16] ^ (s == gidx);
    end
    if (!stop) exp_ferr++;
    else if (rf_full) exp_ovr++;
    else begin
      exp_d[n_exp] = d;
      exp_c[n_exp] = st + LAT;
      n_exp++;
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_nwr"}, n_wr, n_exp);
    for (int i = rd_idx; i < n_exp && i < 64; i++) begin
      chk({tag, "_data"}, {24'd0, got_d[i]}, {24'd0, exp_d[i]});
      chk({tag, "_lat"}, got_c[i], exp_c[i]);
    end
    rd_idx = n_exp;
    chk({tag, "_ferr"}, n_ferr, exp_ferr);
    chk({tag, "_ovr"}, n_ovr, exp_ovr);
    chk({tag, "_overlap"}, n_overlap, 0);
    chk({tag, "_width"}, n_wide, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_rf);
    chk("rst_wr", rf_wr, 0);
    chk("rst_din", {24'd0, rf_din}, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_rf = 1'b0;
    idle(20);

    send_frame(8'hA5, 1'b1, -1, -1);
    idle(20);
    chk("single_busy", busy, 0);
    chk("single_hold", {24'd0, rf_din}, 32'hA5);
    check_events("single");

    send_frame(8'h55, 1'b1, -1, -1);
    send_frame(8'hAA, 1'b1, -1, -1);
    idle(20);
    check_events("b2b");

    repeat (4) begin
      @(negedge clk_rf);
      receiver_rx = 1'b0;
    end
    #1 chk("glitch_busy_hi", busy, 1);
    idle(30);
    chk("glitch_busy_lo", busy, 0);
    check_events("glitch");
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(20);
    check_events("after_glitch");

    send_frame(8'h00, 1'b0, -1, -1);
    repeat (640) @(negedge clk_rf);
    chk("break_busy", busy, 1);
    check_events("break");
    idle(10);
    chk("break_exit", busy, 0);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(20);
    check_events("after_break");

    rf_full = 1'b1;
    send_frame(8'hC3, 1'b1, -1, -1);
    rf_full = 1'b0;
    idle(5);
    send_frame(8'h12, 1'b1, -1, -1);
    idle(20);
    check_events("overrun");

    send_frame(8'hF0, 1'b1, -1, 70);
    @(negedge clk_rf);
    rst_rf = 1'b1;
    receiver_rx = 1'b1;
    #1;
    chk("midrst_wr", rf_wr, 0);
    chk("midrst_din", {24'd0, rf_din}, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(negedge clk_rf);
    rst_rf = 1'b0;
    idle(20);
    check_events("midrst");
    send_frame(8'h7E, 1'b1, -1, -1);
    idle(20);
    check_events("after_rst");

    send_frame(8'h96, 1'b1, 3 * 16 + GOFF, -1);
    idle(20);
    check_events("vote");

    for (int i = 0; i < 10; i++) begin
      rf_full = ($urandom_range(0, 3) == 0);
      send_frame(8'($urandom), 1'b1, -1, -1);
      rf_full = 1'b0;
      idle($urandom_range(0, 12));
    end
    idle(20);
    check_events("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
